// File: rtl/adc_spi_pkg.sv
// Shared constants, FSM encoding and config-word field positions for the
// ADC serial responder.
package adc_spi_pkg;

   localparam int CFG_W  = 6;
   localparam int DATA_W = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Bit positions inside {S/D, O/S, S1, S0, UNI, SLP}
   localparam int SD  = 5;
   localparam int OS  = 4;
   localparam int S1  = 3;
   localparam int S0  = 2;
   localparam int UNI = 1;
   localparam int SLP = 0;

   localparam logic [CFG_W-1:0] CFG_RESET = 6'b100010;

endpackage

// File: rtl/adc_spi_sync.sv
// Multi-flop synchronizer for one asynchronous master pin, with optional
// rise/fall detection against one further registered copy.
module adc_spi_sync #(
   parameter int STAGES  = 2,
   parameter bit RST_VAL = 1'b0,
   parameter bit EDGE_EN = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic a,
   output logic s,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (reset) chain <= {STAGES{RST_VAL}};
      else       chain <= {chain[STAGES-2:0], a};
   end

   assign s = chain[STAGES-1];

   generate
      if (EDGE_EN) begin : g_edge
         logic prev;
         always_ff @(posedge clk) begin
            if (reset) prev <= RST_VAL;
            else       prev <= s;
         end
         assign rise = s & ~prev;
         assign fall = ~s & prev;
      end else begin : g_no_edge
         assign rise = 1'b0;
         assign fall = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/adc_spi_responder.sv
// Device-side LTC2308-style serial responder: captures the 6-bit config word
// and shifts out a 12-bit result chosen by the previously committed config.
module adc_spi_responder #(
   parameter int NUM_CH      = 8,
   parameter int DATA_W      = 12,
   parameter int CFG_W       = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sclk,
   input  logic                     cs_n,
   input  logic                     din,
   output logic                     dout,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [CFG_W-1:0]         cfg_word,
   output logic                     cfg_valid,
   output logic                     short_frame
);

   import adc_spi_pkg::*;

   logic       sclk_rise, sclk_fall, cs_rise, cs_fall, din_s;
   logic       sclk_lvl_unused, cs_lvl_unused;
   logic [1:0] din_edge_unused;

   adc_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_sclk (
      .clk(clk), .reset(reset), .a(sclk),
      .s(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
   );

   // cs_n chain resets low: a pin already low after reset never looks like a
   // falling edge, so a new frame needs a full high-then-low toggle.
   adc_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_cs (
      .clk(clk), .reset(reset), .a(cs_n),
      .s(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
   );

   adc_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_din (
      .clk(clk), .reset(reset), .a(din),
      .s(din_s), .rise(din_edge_unused[0]), .fall(din_edge_unused[1])
   );

   state_e             state;
   logic [3:0]         bit_cnt;
   logic [DATA_W-1:0]  shreg;
   logic [CFG_W-1:0]   cfg_shift;
   logic [2:0]         ch;
   logic [DATA_W-1:0]  sample, result;

   // Result for the frame about to start comes from the committed config.
   always_comb begin
      ch     = {cfg_word[S1], cfg_word[S0], cfg_word[OS]};
      sample = ch_data[int'(ch)*DATA_W +: DATA_W];
      result = sample;
      if (!cfg_word[UNI]) result[DATA_W-1] = ~sample[DATA_W-1];
      if (cfg_word[SLP])  result = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shreg       <= '0;
         cfg_shift   <= '0;
         cfg_word    <= CFG_RESET;
         cfg_valid   <= 1'b0;
         short_frame <= 1'b0;
         dout        <= 1'b0;
      end else begin
         cfg_valid   <= 1'b0;
         short_frame <= 1'b0;
         dout        <= (state == SHIFT) ? shreg[DATA_W-1] : 1'b0;

         // Frame end takes priority over any sclk edge seen in the same cycle.
         if (state != IDLE && cs_rise) begin
            state <= IDLE;
            if (bit_cnt >= 4'(CFG_W)) begin
               cfg_word  <= cfg_shift;
               cfg_valid <= 1'b1;
            end
            if (bit_cnt < 4'(DATA_W)) short_frame <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (cs_fall) begin
                     shreg     <= result;
                     bit_cnt   <= '0;
                     cfg_shift <= '0;
                     state     <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (sclk_rise) begin
                     if (bit_cnt < 4'(CFG_W))
                        cfg_shift <= {cfg_shift[CFG_W-2:0], din_s};
                     if (bit_cnt < 4'(DATA_W)) bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'(DATA_W - 1)) state <= DONE;
                  end else if (sclk_fall && bit_cnt < 4'(DATA_W)) begin
                     shreg <= {shreg[DATA_W-2:0], 1'b0};
                  end
               end
               DONE: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: master-side frames with hand-computed
// results, config commits, short frames and a mid-frame reset.
module tb_adc_spi_responder;

   logic         clk = 1'b0;
   logic         reset;
   logic         sclk, cs_n, din;
   logic         dout;
   logic [95:0]  ch_data;
   logic [5:0]   cfg_word;
   logic         cfg_valid, short_frame;

   int n_cmp = 0;
   int n_err = 0;

   adc_spi_responder dut (
      .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .din(din),
      .dout(dout), .ch_data(ch_data), .cfg_word(cfg_word),
      .cfg_valid(cfg_valid), .short_frame(short_frame)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // n sclk periods of 16 clk; din changes at falling sclk, dout sampled at rising.
   task automatic shift_bits(input logic [5:0] cfg_bits, input int n, output logic [11:0] got);
      got = '0;
      for (int i = 0; i < n; i++) begin
         din = (i < 6) ? cfg_bits[5-i] : 1'b0;
         repeat (8) @(negedge clk);
         if (i < 12) got[11-i] = dout;
         sclk = 1'b1;
         repeat (8) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic frame(input logic [5:0] cfg_bits, input int n, output logic [11:0] got,
                        output int cv, output int sf, output int lat);
      @(negedge clk);
      cs_n = 1'b0;
      shift_bits(cfg_bits, n, got);
      cs_n = 1'b1;
      cv = 0; sf = 0; lat = -1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (cfg_valid) begin
            cv++;
            if (lat < 0) lat = k;
         end
         if (short_frame) sf++;
      end
   endtask

   initial begin
      logic [11:0] got;
      int cv, sf, lat, act;

      reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; din = 1'b0;
      ch_data = '0;
      ch_data[0*12 +: 12] = 12'hA5C;
      ch_data[6*12 +: 12] = 12'h123;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_dout",  dout, 1'b0);
      chk("rst_cfg",   cfg_word, 6'b100010);
      chk("rst_cv",    cfg_valid, 1'b0);
      chk("rst_sf",    short_frame, 1'b0);

      // Default config: CH0 unipolar
      frame(6'b100010, 12, got, cv, sf, lat);
      chk("def_data", got, 12'hA5C);
      chk("def_cv",   cv, 1);
      chk("def_sf",   sf, 0);
      chk("def_lat",  lat, 3);
      chk("def_cfg",  cfg_word, 6'b100010);

      // Select CH6; result only changes on the following frame
      frame(6'b101110, 12, got, cv, sf, lat);
      chk("ch6_pipe_data", got, 12'hA5C);
      chk("ch6_cfg",       cfg_word, 6'b101110);
      frame(6'b100010, 12, got, cv, sf, lat);
      chk("ch6_data",      got, 12'h123);

      // Bipolar on CH0, then sleep request
      ch_data[0*12 +: 12] = 12'h000;
      frame(6'b100000, 12, got, cv, sf, lat);
      chk("bip_pipe_data", got, 12'h000);
      frame(6'b100001, 12, got, cv, sf, lat);
      chk("bip_data",      got, 12'h800);

      ch_data = {8{12'hFFF}};
      frame(6'b100010, 12, got, cv, sf, lat);
      chk("slp_data",      got, 12'h000);

      // Short frames: 4 edges (no commit), 7 edges (commit)
      frame(6'b101110, 4, got, cv, sf, lat);
      chk("sh4_data", got, 12'hF00);
      chk("sh4_sf",   sf, 1);
      chk("sh4_cv",   cv, 0);
      chk("sh4_cfg",  cfg_word, 6'b100010);
      frame(6'b101110, 7, got, cv, sf, lat);
      chk("sh7_data", got, 12'hFE0);
      chk("sh7_sf",   sf, 1);
      chk("sh7_cv",   cv, 1);
      chk("sh7_cfg",  cfg_word, 6'b101110);

      // Reset with cs_n held low after 5 edges
      @(negedge clk);
      cs_n = 1'b0;
      shift_bits(6'b100001, 5, got);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_dout", dout, 1'b0);
      chk("mid_cfg",  cfg_word, 6'b100010);
      act = 0;
      for (int i = 0; i < 3; i++) begin
         repeat (8) @(negedge clk);
         if (dout || cfg_valid || short_frame) act++;
         sclk = 1'b1;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dout || cfg_valid || short_frame) act++;
         end
         sclk = 1'b0;
      end
      cs_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (dout || cfg_valid || short_frame) act++;
      end
      chk("mid_quiet", act, 0);
      chk("mid_cfg2",  cfg_word, 6'b100010);

      ch_data[0*12 +: 12] = 12'h3C7;
      frame(6'b100010, 12, got, cv, sf, lat);
      chk("post_data", got, 12'h3C7);
      chk("post_cv",   cv, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable responder for the four-wire ADC serial interface (sclk, cs_n, din, dout) that the SoC's ADC controller drives as master. It is the device-side counterpart of the LTC2308-style converter. It oversamples the master's signals on the fabric clock, captures the 6-bit configuration word, and shifts out a 12-bit result chosen from parallel channel inputs. Its uses are hardware-in-loop emulation of the converter and closed-loop verification of the ADC path.

## Interface
Parameters:
- NUM_CH, 8: channel count; fixed at 8 by the channel-address decode.
- DATA_W, 12: result width.
- CFG_W, 6: configuration word width.
- SYNC_STAGES, 2: synchronizer depth on sclk, cs_n and din; minimum 2.

Ports:
- clk  in  1  fabric clock. One clock domain.
- reset  in  1  synchronous, active-high.
- sclk  in  1  serial clock from master, asynchronous to clk.
- cs_n  in  1  frame select from master, active-low, asynchronous.
- din  in  1  configuration bits from master; MSB first; master changes it on falling sclk.
- dout  out  1  result bits to master; MSB first; changes after falling sclk.
- ch_data  in  NUM_CH*DATA_W  flattened offset-binary samples; channel n is at [n*DATA_W +: DATA_W].
- cfg_word  out  CFG_W  last committed configuration word {S/D, O/S, S1, S0, UNI, SLP}.
- cfg_valid  out  1  one-cycle pulse when cfg_word updates.
- short_frame  out  1  one-cycle pulse when cs_n rises before 12 rising sclk edges.

## Operation
- All three master inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk and cs_n against one further registered copy.
- **Pipelined behaviour:** the result shifted out in frame N is set by the configuration committed at the end of frame N-1.
- **Channel select:** ch = {S1, S0, O/S}. S/D=0 (differential) returns the same channel as S/D=1.
- **Coding:**
  - UNI=1: result = ch_data[ch].
  - UNI=0: result = ch_data[ch] with the MSB inverted (offset binary to two's complement).
  - SLP=1: the next frame returns all zeros.
- **FSM states:**
  - IDLE: dout=0. On synchronized cs_n falling, load the shift register with the result, clear bit_cnt and cfg_shift, then go to SHIFT. dout shows the result MSB from the next cycle.
  - SHIFT:
    - On each sclk rising edge: if bit_cnt<CFG_W, shift din into cfg_shift; then bit_cnt++.
    - On each sclk falling edge: if bit_cnt<DATA_W, shift the next bit onto dout.
    - When bit_cnt reaches DATA_W, go to DONE.
  - DONE: dout=0. Further sclk edges are ignored.
- **cs_n rising, from SHIFT or DONE:**
  - Return to IDLE.
  - If bit_cnt>=CFG_W: commit cfg_shift to cfg_word and pulse cfg_valid.
  - If bit_cnt<DATA_W: pulse short_frame.
- **Simultaneous events:** if cs_n rising and an sclk edge are detected in the same cycle, cs_n wins and that sclk edge is discarded.
- **ch_data sampling:** ch_data is sampled only at frame start. Changes during a frame have no effect.

## Timing
- **Reset values:** dout=0, cfg_word=6'b100010 (CH0, single-ended, unipolar, awake), cfg_valid=0, short_frame=0, FSM=IDLE, bit_cnt=0. The pending config used for the first frame is also 6'b100010.
- **Reset mid-frame:** abort without committing the config or pulsing any output. The block then waits in IDLE for the next cs_n falling edge; it does not react to a cs_n already low.
- **Latency:**
  - dout settles SYNC_STAGES+2 clk cycles after the pin-level falling sclk (4 cycles at default).
  - The MSB is valid SYNC_STAGES+2 cycles after cs_n falls.
- **Clock requirement:** clk must be at least 8 times sclk, and the master must hold cs_n low for at least 4 clk cycles before the first sclk rising edge.
- cfg_valid and short_frame assert SYNC_STAGES+1 cycles after cs_n rises at the pin.
- bit_cnt is 4 bits wide and saturates at DATA_W; it never wraps.

## Structure
- Package adc_spi_pkg holds:
  - CFG_W and DATA_W constants.
  - The FSM state enum {IDLE, SHIFT, DONE}.
  - Field localparams for cfg bit positions (SD=5, OS=4, S1=3, S0=2, UNI=1, SLP=0).
  - Reset config constant CFG_RESET=6'b100010.
- One sub-module, adc_spi_sync: a SYNC_STAGES flop chain plus an edge detector. It is instantiated for sclk and cs_n; din uses the chain only.

## Test plan
- **Reset default:** after reset, ch_data[0]=12'hA5C. Run a 12-clock frame with din=6'b100010 → dout carries 1010_0101_1100 and cfg_valid pulses once with cfg_word=6'b100010.
- **Channel/pipeline:**
  - Frame 1 sends din=6'b101110 (ch={1,1,0}=6, UNI=1).
  - Frame 2 returns ch_data[6]=12'h123, with dout=0001_0010_0011.
- **Bipolar:** commit UNI=0 on CH0, with ch_data[0]=12'h000 → next frame dout=12'h800.
- **Sleep:** commit SLP=1, with ch_data=all 12'hFFF → next frame returns 12'h000.
- **Short frame:** raise cs_n after 4 sclk rising edges → short_frame pulses, cfg_valid stays 0, and cfg_word is unchanged. After 7 edges → both short_frame and cfg_valid pulse.
- **Reset mid-frame:** assert reset after 5 sclk edges with cs_n held low → dout=0 and cfg_word=6'b100010. No activity until cs_n toggles high then low again.
